// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - four-phase fetch/decode/execute/writeback sequencer
// Fetches opcodes from program memory with ack handshake, timeout fault and single-step.
module instr_sequencer #(
  parameter int PC_WIDTH      = 4,
  parameter int PROG_LEN      = 16,
  parameter bit LOOP          = 1'b1,
  parameter int FETCH_TIMEOUT = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_step,
  output logic [PC_WIDTH-1:0] o_rom_addr,
  output logic                o_rom_req,
  input  logic                i_rom_ack,
  input  logic [3:0]          i_rom_data,
  output logic [3:0]          o_instr_out,
  output logic                o_exec_en,
  output logic [1:0]          o_phase,
  output logic                o_busy,
  output logic                o_halted,
  output logic                o_fault,
  output logic [7:0]          o_retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [PC_WIDTH-1:0] LAST_PC   = PC_WIDTH'(PROG_LEN - 1);
  localparam logic [7:0]          WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [3:0]            r_instr;
  logic [7:0]            r_retired;
  logic [7:0]            r_wait;
  logic                  r_single;
  logic                  r_fault;
  logic                  w_last;
  logic                  w_timeout;

  assign w_last    = (r_pc == LAST_PC);
  assign w_timeout = (r_state == S_FETCH) && !i_rom_ack && (r_wait == WAIT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_run || i_step) w_next = S_FETCH;
      S_FETCH: begin
        if (i_rom_ack)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_HALT;
      end
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_WRITEBACK: begin
        // End of a non-looping program halts even if run is still high.
        if (w_last && !LOOP)           w_next = S_HALT;
        else if (r_single || !i_run)   w_next = S_IDLE;
        else                           w_next = S_FETCH;
      end
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pc      <= '0;
      r_instr   <= '0;
      r_retired <= '0;
      r_wait    <= '0;
      r_single  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      if (r_state == S_FETCH && !i_rom_ack) r_wait <= r_wait + 8'd1;
      else                                  r_wait <= '0;

      case (r_state)
        S_IDLE: begin
          if (i_run)       r_single <= 1'b0;
          else if (i_step) r_single <= 1'b1;
        end
        S_FETCH: begin
          if (i_rom_ack)      r_instr <= i_rom_data;
          else if (w_timeout) r_fault <= 1'b1;
        end
        S_WRITEBACK: begin
          r_retired <= r_retired + 8'd1;
          if (!w_last)  r_pc <= r_pc + PC_WIDTH'(1);
          else if (LOOP) r_pc <= '0;
          if (w_next == S_IDLE) r_single <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_phase = 2'd0;
    case (r_state)
      S_DECODE:    o_phase = 2'd1;
      S_EXECUTE:   o_phase = 2'd2;
      S_WRITEBACK: o_phase = 2'd3;
      default:     o_phase = 2'd0;
    endcase
  end

  assign o_rom_addr  = r_pc;
  assign o_rom_req   = (r_state == S_FETCH);
  assign o_exec_en   = (r_state == S_EXECUTE);
  assign o_busy      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                       (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);
  assign o_halted    = (r_state == S_HALT);
  assign o_fault     = r_fault;
  assign o_instr_out = r_instr;
  assign o_retired   = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
// Transaction-level model: each instruction is fetch(waits+1), decode, execute, writeback.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run0, step0, ack0;
  logic [3:0] data0;
  logic [3:0] addr0, instr0;
  logic       req0, exec0, busy0, halted0, fault0;
  logic [1:0] phase0;
  logic [7:0] retired0;

  logic       run1, step1, ack1;
  logic [3:0] data1;
  logic [1:0] addr1;
  logic [3:0] instr1;
  logic       req1, exec1, busy1, halted1, fault1;
  logic [1:0] phase1;
  logic [7:0] retired1;

  logic [3:0] rom  [16];
  logic [3:0] rom1 [4];
  int         m_pc;
  logic [7:0] m_ret;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  assign data1 = rom1[addr1];

  instr_sequencer dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_run(run0), .i_step(step0),
    .o_rom_addr(addr0), .o_rom_req(req0), .i_rom_ack(ack0), .i_rom_data(data0),
    .o_instr_out(instr0), .o_exec_en(exec0), .o_phase(phase0), .o_busy(busy0),
    .o_halted(halted0), .o_fault(fault0), .o_retired(retired0)
  );

  instr_sequencer #(.PC_WIDTH(2), .PROG_LEN(4), .LOOP(1'b0), .FETCH_TIMEOUT(8)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_run(run1), .i_step(step1),
    .o_rom_addr(addr1), .o_rom_req(req1), .i_rom_ack(ack1), .i_rom_data(data1),
    .o_instr_out(instr1), .o_exec_en(exec1), .o_phase(phase1), .o_busy(busy1),
    .o_halted(halted1), .o_fault(fault1), .o_retired(retired1)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    run0 = 0; step0 = 0; ack0 = 0; data0 = 0;
    run1 = 0; step1 = 0; ack1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc  = 0;
    m_ret = 8'd0;
  endtask

  // Entered at the negedge of the first FETCH cycle; returns at the negedge after WRITEBACK.
  task automatic run_instr(input int waits, input bit drop_run);
    logic [5:0] st;
    for (int i = 0; i <= waits; i++) begin
      st = {req0, exec0, busy0, halted0, phase0};
      n_tests++;
      if (st !== 6'b101000) begin n_fail++; $display("FAIL fetch_status got %b expected 101000 pc=%0d", st, m_pc); end
      n_tests++;
      if (addr0 !== 4'(m_pc)) begin n_fail++; $display("FAIL fetch_addr got %0d expected %0d", addr0, m_pc); end
      ack0  = (i == waits);
      data0 = (i == waits) ? rom[m_pc] : 4'($urandom);
      @(negedge clk);
    end
    ack0 = 1'($urandom); data0 = 4'($urandom); step0 = 1'($urandom);
    st = {req0, exec0, busy0, halted0, phase0};
    n_tests++;
    if (st !== 6'b001001) begin n_fail++; $display("FAIL decode_status got %b expected 001001", st); end
    n_tests++;
    if (instr0 !== rom[m_pc]) begin n_fail++; $display("FAIL decode_instr got %0h expected %0h", instr0, rom[m_pc]); end
    n_tests++;
    if (retired0 !== m_ret) begin n_fail++; $display("FAIL retired got %0d expected %0d", retired0, m_ret); end
    if (drop_run) run0 = 1'b0;
    @(negedge clk);
    ack0 = 1'($urandom); data0 = 4'($urandom); step0 = 1'($urandom);
    st = {req0, exec0, busy0, halted0, phase0};
    n_tests++;
    if (st !== 6'b011010) begin n_fail++; $display("FAIL execute_status got %b expected 011010", st); end
    n_tests++;
    if (instr0 !== rom[m_pc]) begin n_fail++; $display("FAIL execute_instr got %0h expected %0h", instr0, rom[m_pc]); end
    @(negedge clk);
    ack0 = 1'b0; step0 = 1'b0;
    st = {req0, exec0, busy0, halted0, phase0};
    n_tests++;
    if (st !== 6'b001011) begin n_fail++; $display("FAIL writeback_status got %b expected 001011", st); end
    n_tests++;
    if (instr0 !== rom[m_pc]) begin n_fail++; $display("FAIL writeback_instr got %0h expected %0h", instr0, rom[m_pc]); end
    m_ret = m_ret + 8'd1;
    m_pc  = (m_pc + 1) % 16;
    @(negedge clk);
  endtask

  task automatic expect_idle(input string name);
    logic [5:0] st;
    st = {req0, exec0, busy0, halted0, phase0};
    n_tests++;
    if (st !== 6'b000000) begin n_fail++; $display("FAIL %s_status got %b expected 000000", name, st); end
    n_tests++;
    if (addr0 !== 4'(m_pc)) begin n_fail++; $display("FAIL %s_pc got %0d expected %0d", name, addr0, m_pc); end
    n_tests++;
    if (retired0 !== m_ret) begin n_fail++; $display("FAIL %s_retired got %0d expected %0d", name, retired0, m_ret); end
  endtask

  task automatic test_reset();
    logic [25:0] v;
    do_reset();
    v = {req0, exec0, busy0, halted0, fault0, phase0, addr0, instr0, retired0, req1, halted1, fault1};
    n_tests++;
    if (v !== 26'd0) begin n_fail++; $display("FAIL reset_state got %h expected 0", v); end
    run0 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req0 !== 1'b1) begin n_fail++; $display("FAIL reset_pre_fetch got %b expected 1", req0); end
    ack0 = 1'b1; data0 = 4'hA; rst_n = 1'b0;
    @(negedge clk);
    v = {req0, exec0, busy0, halted0, fault0, phase0, addr0, instr0, retired0, 3'b000};
    n_tests++;
    if (v !== 26'd0) begin n_fail++; $display("FAIL reset_mid_fetch got %h expected 0", v); end
    rst_n = 1'b1; run0 = 1'b0; ack0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({exec0, busy0} !== 2'b00) begin n_fail++; $display("FAIL reset_no_exec got %b expected 00", {exec0, busy0}); end
    end
  endtask

  task automatic test_run_loop();
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    run0 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 17; k++) run_instr(0, 1'b0);
    n_tests++;
    if (retired0 !== 8'd17) begin n_fail++; $display("FAIL loop_retired17 got %0d expected 17", retired0); end
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
    for (int k = 0; k < 20; k++) run_instr(int'($urandom_range(0, 3)), 1'b0);
    run_instr(int'($urandom_range(0, 3)), 1'b1);
    expect_idle("loop_stop");
  endtask

  task automatic test_step();
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
    step0 = 1'b1;
    @(negedge clk);
    step0 = 1'b0;
    run_instr(2, 1'b0);
    n_tests++;
    if ({addr0, retired0} !== {4'd1, 8'd1}) begin n_fail++; $display("FAIL step_pc_retired got %0d/%0d expected 1/1", addr0, retired0); end
    expect_idle("step_first");
    for (int k = 0; k < 5; k++) begin
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
      step0 = 1'b1;
      @(negedge clk);
      step0 = 1'b0;
      run_instr(int'($urandom_range(0, 3)), 1'b0);
      expect_idle("step_loop");
    end
  endtask

  task automatic test_drop_run();
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
    run0 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) run_instr(int'($urandom_range(0, 2)), 1'b0);
    run_instr(0, 1'b1);
    n_tests++;
    if (addr0 !== 4'd6) begin n_fail++; $display("FAIL drop_pc got %0d expected 6", addr0); end
    expect_idle("drop_idle");
    run0 = 1'b1;
    @(negedge clk);
    run_instr(0, 1'b0);
    run_instr(1, 1'b1);
    expect_idle("drop_resume");
  endtask

  task automatic test_reset_mid_execute();
    logic [21:0] v;
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
    run0 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) run_instr(0, 1'b0);
    ack0 = 1'b1; data0 = rom[9];
    @(negedge clk);
    ack0 = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({exec0, addr0} !== {1'b1, 4'd9}) begin n_fail++; $display("FAIL midexec_pre got %b/%0d expected 1/9", exec0, addr0); end
    rst_n = 1'b0;
    @(negedge clk);
    v = {exec0, busy0, phase0, addr0, instr0, retired0, halted0, fault0};
    n_tests++;
    if (v !== 22'd0) begin n_fail++; $display("FAIL midexec_reset got %h expected 0", v); end
    rst_n = 1'b1; m_pc = 0; m_ret = 8'd0;
    run0 = 1'b1; step0 = 1'b1;
    @(negedge clk);
    step0 = 1'b0;
    for (int k = 0; k < 3; k++) run_instr(int'($urandom_range(0, 2)), 1'b0);
    run_instr(0, 1'b1);
    expect_idle("run_step_both");
  endtask

  task automatic test_timeout();
    int cyc = 0;
    do_reset();
    run0 = 1'b1; ack0 = 1'b0;
    @(negedge clk);
    while (req0 === 1'b1 && cyc < 20) begin
      n_tests++;
      if (exec0 !== 1'b0) begin n_fail++; $display("FAIL timeout_exec got %b expected 0", exec0); end
      cyc++;
      @(negedge clk);
    end
    n_tests++;
    if (cyc != 8) begin n_fail++; $display("FAIL timeout_req_cycles got %0d expected 8", cyc); end
    n_tests++;
    if ({halted0, fault0, busy0, req0, exec0} !== 5'b11000) begin
      n_fail++; $display("FAIL timeout_halt got %b expected 11000", {halted0, fault0, busy0, req0, exec0});
    end
    for (int k = 0; k < 10; k++) begin
      run0 = 1'($urandom); step0 = 1'($urandom); ack0 = 1'($urandom);
      @(negedge clk);
      n_tests++;
      if ({req0, exec0, halted0, fault0} !== 4'b0011) begin
        n_fail++; $display("FAIL timeout_sticky got %b expected 0011", {req0, exec0, halted0, fault0});
      end
    end
    run0 = 1'b0; step0 = 1'b0; ack0 = 1'b0;
  endtask

  task automatic test_no_loop();
    int cyc = 0;
    int execs = 0;
    do_reset();
    for (int i = 0; i < 4; i++) rom1[i] = 4'($urandom);
    ack1 = 1'b1; run1 = 1'b1;
    @(negedge clk);
    while (halted1 !== 1'b1 && cyc < 50) begin
      if (exec1 === 1'b1) begin
        n_tests++;
        if (instr1 !== rom1[execs % 4]) begin n_fail++; $display("FAIL noloop_instr got %0h expected %0h", instr1, rom1[execs % 4]); end
        execs++;
      end
      cyc++;
      @(negedge clk);
    end
    n_tests++;
    if (execs != 4) begin n_fail++; $display("FAIL noloop_execs got %0d expected 4", execs); end
    n_tests++;
    if (cyc != 16) begin n_fail++; $display("FAIL noloop_cycles got %0d expected 16", cyc); end
    n_tests++;
    if ({halted1, fault1, busy1, addr1, retired1} !== {3'b100, 2'd3, 8'd4}) begin
      n_fail++; $display("FAIL noloop_halt got %b/%0d/%0d expected 100/3/4", {halted1, fault1, busy1}, addr1, retired1);
    end
    for (int k = 0; k < 10; k++) begin
      run1 = 1'($urandom); step1 = 1'($urandom);
      @(negedge clk);
      n_tests++;
      if ({req1, exec1, halted1} !== 3'b001) begin n_fail++; $display("FAIL noloop_sticky got %b expected 001", {req1, exec1, halted1}); end
    end
    run1 = 1'b0; step1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    run0 = 0; step0 = 0; ack0 = 0; data0 = 0;
    run1 = 0; step1 = 0; ack1 = 0;
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    for (int i = 0; i < 4; i++) rom1[i] = 4'(i);
    @(negedge clk);
    test_reset();
    test_run_loop();
    test_step();
    test_drop_run();
    test_reset_mid_execute();
    test_timeout();
    test_no_loop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 4, program counter width.
REQ-002 Parameter PROG_LEN, default 16, number of program words (2..2^PC_WIDTH).
REQ-003 Parameter LOOP, default 1; 1 = PC wraps to 0 after the last word, 0 = halt after the last word.
REQ-004 Parameter FETCH_TIMEOUT, default 8, maximum FETCH cycles waiting for rom_ack (1..255).
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; sampled on the rising clk edge; one clock, no other clock domain.
REQ-007 run  input  1  level; continuous execution while high.
REQ-008 step  input  1  single-cycle pulse; execute exactly one instruction from IDLE.
REQ-009 rom_addr  output  PC_WIDTH  program memory address, equals PC.
REQ-010 rom_req  output  1  fetch request, high in FETCH only.
REQ-011 rom_ack  input  1  fetch acknowledge; rom_data valid in the same cycle.
REQ-012 rom_data  input  4  opcode from program memory.
REQ-013 instr_out  output  4  latched opcode driving the instruction decoder.
REQ-014 exec_en  output  1  datapath/accumulator enable, high for exactly the EXECUTE cycle.
REQ-015 phase  output  2  0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK; 0 outside these states.
REQ-016 busy  output  1  high in FETCH, DECODE, EXECUTE, WRITEBACK.
REQ-017 halted  output  1  high in HALT.
REQ-018 fault  output  1  high in HALT when entered by fetch timeout.
REQ-019 retired  output  8  count of instructions completed, wraps 255->0.

Function
REQ-020 States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT; exactly one active.
REQ-021 IDLE: run=1 -> FETCH; else step=1 -> FETCH with single-step flag set; run and step both high -> run wins, flag clear.
REQ-022 FETCH: rom_req=1, rom_addr=PC; rom_ack sampled every FETCH cycle including the first; on ack, rom_data latched into instr_out and -> DECODE.
REQ-023 FETCH wait counter clears on FETCH entry and increments each cycle without ack; ack absent in the FETCH_TIMEOUT-th cycle -> HALT with fault=1.
REQ-024 rom_ack outside FETCH is ignored; instr_out does not change.
REQ-025 DECODE: one cycle, instr_out stable -> EXECUTE.
REQ-026 EXECUTE: one cycle, exec_en=1 -> WRITEBACK; instr_out unchanged through WRITEBACK.
REQ-027 WRITEBACK: one cycle; retired increments; PC advances per REQ-028; next state: single-step flag set or run=0 -> IDLE (flag cleared); else -> FETCH.
REQ-028 PC advance: PC<PROG_LEN-1 -> PC+1; PC=PROG_LEN-1 and LOOP=1 -> 0; PC=PROG_LEN-1 and LOOP=0 -> PC held, next state HALT, fault=0, overriding REQ-027.
REQ-029 run dropping mid-instruction completes the current instruction; pause only at WRITEBACK; PC retained, resume from IDLE at the next PC.
REQ-030 step in any state other than IDLE is ignored.
REQ-031 HALT is exited only by reset; run and step ignored.
REQ-032 Minimum throughput: one instruction per 4 cycles with zero-wait ack; each ROM wait cycle adds one cycle.

Reset
REQ-033 reset=0 at a rising edge -> IDLE, PC=0, instr_out=0, retired=0, fetch counter=0, single-step flag=0, fault=0; rom_req=0, exec_en=0, busy=0, halted=0, phase=0.
REQ-034 Reset overrides all other inputs in any state, including mid-FETCH with rom_ack high; no exec_en pulse follows.

Verification
REQ-035 Run, zero-wait ack, ROM holds 0..F, LOOP=1: exec_en every 4th cycle, instr_out 0,1,..,F,0; rom_addr wraps F->0; retired=17 after 17 instructions.
REQ-036 LOOP=0, PROG_LEN=4, run held: 4 exec_en pulses, then halted=1, fault=0, PC=3; run/step afterwards produce no rom_req.
REQ-037 Step pulse from IDLE, ack on 3rd FETCH cycle: one exec_en, rom_req high 3 cycles, back to IDLE after 6 cycles, PC=1, retired=1.
REQ-038 FETCH_TIMEOUT=8, rom_ack held low: rom_req high 8 cycles, then halted=1, fault=1, exec_en never asserted.
REQ-039 run dropped during DECODE at PC=5: exec_en pulses once, IDLE with PC=6; run reasserted -> rom_addr=6.
REQ-040 reset=0 during EXECUTE at PC=9: next cycle IDLE, PC=0, retired=0, instr_out=0, exec_en=0; run and step together from IDLE -> continuous execution.
